// File: rtl/mini_alu_core_if.sv
// mini_alu_core_if
//   Peripheral I/O bus of the mini ALU core: one request at a time with a
//   valid/ready handshake. The core drives the request; a peripheral adapter
//   (LCD, LED, VGA RAM, PS/2) decodes oIoAddr and answers with iIoReady.
//
//   oIoValid  core -> periph  request pending
//   oIoWrite  core -> periph  1 = OUT (write), 0 = IN (read); meaningful while oIoValid
//   oIoAddr   core -> periph  peripheral address
//   oIoData   core -> periph  write data
//   iIoReady  periph -> core  request accepted/completed this cycle
//   iIoData   periph -> core  read data, sampled in the IN transfer cycle
interface mini_alu_core_if #(
  parameter int DATA_W = 16
);
  logic              oIoValid;
  logic              oIoWrite;
  logic [DATA_W-1:0] oIoAddr;
  logic [DATA_W-1:0] oIoData;
  logic              iIoReady;
  logic [DATA_W-1:0] iIoData;

  modport master (
    output oIoValid,
    output oIoWrite,
    output oIoAddr,
    output oIoData,
    input  iIoReady,
    input  iIoData
  );

  modport slave (
    input  oIoValid,
    input  oIoWrite,
    input  oIoAddr,
    input  oIoData,
    output iIoReady,
    output iIoData
  );
endinterface

// File: rtl/mini_alu_core.sv
// mini_alu_core
//   Two-stage (fetch/execute) execute engine with an internal register file,
//   a hardware return stack for CALL/RET, a valid/ready I/O port and
//   terminal HALT/FAULT states.
//
//   Clock     in   system clock, all state on posedge
//   Reset     in   asynchronous, active-low
//   oIAddr    out  instruction ROM address (= PC)
//   iInstr    in   ROM word, combinational from oIAddr
//   io        mst  peripheral bus (mini_alu_core_if.master)
//   oHalted   out  HALT has executed
//   oFault    out  return-stack overflow/underflow
//   oRsDepth  out  return-stack occupancy
//
//   Instruction word: {op[3:0], dst, src1, src0}; imm = {src1, src0}.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   StRun    | normal fetch/execute, one instruction per cycle
//   StIoWait | OUT/IN in IR waiting for iIoReady; PC, IR and bus held
//   StHalt   | HALT executed; PC frozen, no writes, left only by reset
//   StFault  | stack overflow/underflow; PC frozen, left only by reset
module mini_alu_core #(
  parameter int DATA_W   = 16,
  parameter int RA_W     = 8,
  parameter int PC_W     = 16,
  parameter int RS_DEPTH = 8,
  localparam int INSTR_W = 4 + 3 * RA_W,
  localparam int RSD_W   = $clog2(RS_DEPTH + 1)
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [PC_W-1:0]    oIAddr,
  input  logic [INSTR_W-1:0] iInstr,
  mini_alu_core_if.master    io,
  output logic               oHalted,
  output logic               oFault,
  output logic [RSD_W-1:0]   oRsDepth
);

  localparam int IMM_W = 2 * RA_W;
  localparam int RSI_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_MUL  = 4'd3,
    OP_STO  = 4'd4,
    OP_BLE  = 4'd5,
    OP_JMP  = 4'd6,
    OP_CALL = 4'd7,
    OP_RET  = 4'd8,
    OP_OUT  = 4'd9,
    OP_IN   = 4'd10,
    OP_AND  = 4'd11,
    OP_OR   = 4'd12,
    OP_XOR  = 4'd13,
    OP_SHL  = 4'd14,
    OP_HALT = 4'd15
  } opT;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StIoWait = 2'd1,
    StHalt   = 2'd2,
    StFault  = 2'd3
  } stateT;

  stateT              state, stateNext;
  logic [PC_W-1:0]    pc, pcNext;
  logic [PC_W-1:0]    irPc, irPcNext;
  logic [INSTR_W-1:0] ir, irNext;
  logic [RSD_W-1:0]   rsDepth, rsDepthNext;

  // Neither storage array is reset: software initialises registers with STO,
  // and stack slots are only read below the occupancy count.
  logic [DATA_W-1:0]  regFile  [2**RA_W];
  logic [PC_W-1:0]    retStack [RS_DEPTH];

  opT                 op;
  logic [RA_W-1:0]    dst, src1, src0;
  logic [DATA_W-1:0]  rdA, rdB;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  immExt;
  logic [PC_W-1:0]    target;
  logic [DATA_W-1:0]  aluOut;
  logic               regWe;
  logic               rsPush;
  logic [RSI_W-1:0]   pushIdx, popIdx;
  logic [PC_W-1:0]    rsTop;
  logic               isIo;

  // Instruction field decode
  assign op   = opT'(ir[INSTR_W-1 -: 4]);
  assign dst  = ir[3*RA_W-1 -: RA_W];
  assign src1 = ir[2*RA_W-1 -: RA_W];
  assign src0 = ir[RA_W-1:0];
  assign imm  = {src1, src0};

  // Combinational register reads: a write at the end of one execute cycle is
  // visible to the very next instruction, so no interlock is needed.
  assign rdA = regFile[src1];
  assign rdB = regFile[src0];

  generate
    if (IMM_W >= DATA_W) begin : gImmTrunc
      assign immExt = imm[DATA_W-1:0];
    end else begin : gImmZext
      assign immExt = {{(DATA_W-IMM_W){1'b0}}, imm};
    end

    if (RA_W >= PC_W) begin : gTgtTrunc
      assign target = dst[PC_W-1:0];
    end else begin : gTgtZext
      assign target = {{(PC_W-RA_W){1'b0}}, dst};
    end
  endgenerate

  // Stack slot addressing; the slot index is the occupancy count truncated to
  // the array index width (a push never happens at full depth).
  assign pushIdx = rsDepth[RSI_W-1:0];
  assign popIdx  = pushIdx - RSI_W'(1);
  assign rsTop   = retStack[popIdx];

  always_comb begin
    aluOut = '0;
    case (op)
      OP_ADD:  aluOut = rdA + rdB;
      OP_SUB:  aluOut = rdA - rdB;
      OP_MUL:  aluOut = rdA * rdB;
      OP_STO:  aluOut = immExt;
      OP_IN:   aluOut = io.iIoData;
      OP_AND:  aluOut = rdA & rdB;
      OP_OR:   aluOut = rdA | rdB;
      OP_XOR:  aluOut = rdA ^ rdB;
      OP_SHL:  aluOut = rdA << rdB[3:0];
      default: aluOut = '0;
    endcase
  end

  // I/O request is purely a function of the held IR and state, so an async
  // reset (IR <= NOP) drops oIoValid immediately.
  assign isIo        = (op == OP_OUT) || (op == OP_IN);
  assign io.oIoValid = isIo && ((state == StRun) || (state == StIoWait));
  assign io.oIoWrite = (op == OP_OUT);
  assign io.oIoAddr  = rdB;
  assign io.oIoData  = rdA;

  // Next-state / control
  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    irNext      = ir;
    irPcNext    = irPc;
    rsDepthNext = rsDepth;
    regWe       = 1'b0;
    rsPush      = 1'b0;

    case (state)
      StRun: begin
        pcNext   = pc + PC_W'(1);
        irNext   = iInstr;
        irPcNext = pc;
        case (op)
          OP_ADD, OP_SUB, OP_MUL, OP_STO,
          OP_AND, OP_OR, OP_XOR, OP_SHL: regWe = 1'b1;
          OP_BLE: begin
            if (rdA <= rdB) begin
              pcNext = target;
              irNext = '0;
            end
          end
          OP_JMP: begin
            pcNext = target;
            irNext = '0;
          end
          OP_CALL: begin
            if (rsDepth == RSD_W'(RS_DEPTH)) begin
              stateNext = StFault;
              pcNext    = pc;
              irNext    = ir;
              irPcNext  = irPc;
            end else begin
              rsPush      = 1'b1;
              rsDepthNext = rsDepth + RSD_W'(1);
              pcNext      = target;
              irNext      = '0;
            end
          end
          OP_RET: begin
            if (rsDepth == '0) begin
              stateNext = StFault;
              pcNext    = pc;
              irNext    = ir;
              irPcNext  = irPc;
            end else begin
              rsDepthNext = rsDepth - RSD_W'(1);
              pcNext      = rsTop;
              irNext      = '0;
            end
          end
          OP_OUT, OP_IN: begin
            if (io.iIoReady) begin
              regWe = (op == OP_IN);
            end else begin
              stateNext = StIoWait;
              pcNext    = pc;
              irNext    = ir;
              irPcNext  = irPc;
            end
          end
          OP_HALT: begin
            stateNext = StHalt;
            pcNext    = pc;
            irNext    = ir;
            irPcNext  = irPc;
          end
          default: ;
        endcase
      end

      StIoWait: begin
        // PC already points past the stalled instruction, so iInstr is the
        // next word to load on completion.
        if (io.iIoReady) begin
          stateNext = StRun;
          pcNext    = pc + PC_W'(1);
          irNext    = iInstr;
          irPcNext  = pc;
          regWe     = (op == OP_IN);
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= StRun;
      pc      <= '0;
      ir      <= '0;
      irPc    <= '0;
      rsDepth <= '0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      ir      <= irNext;
      irPc    <= irPcNext;
      rsDepth <= rsDepthNext;
    end
  end

  always_ff @(posedge Clock) begin
    if (regWe) begin
      regFile[dst] <= aluOut;
    end
    if (rsPush) begin
      retStack[pushIdx] <= irPc + PC_W'(1);
    end
  end

  assign oIAddr   = pc;
  assign oHalted  = (state == StHalt);
  assign oFault   = (state == StFault);
  assign oRsDepth = rsDepth;

endmodule
